multicycle_ctrl: RTL and testbench

- Multicycle control unit that sequences a shared-memory MIPS datapath: one ALU, one memory port, an instruction register, and PC/register-file write enables.
- Decodes opcode/funct and steps a Moore FSM, one state per datapath phase.
- Holds in memory states until the memory handshake completes.
- Sits beside the datapath; drives every mux select, write enable and ALU control.

---
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences a shared-memory
// datapath (one ALU, one memory port, IR, PC and register-file enables).
// Every output is decoded combinationally from the current state plus
// op/funct/zero/mem_ready. There is no output register.
module multicycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               memwrite,
  output logic               iord,
  output logic               irwrite,
  output logic               pcen,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [2:0]         alucontrol,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BEQ     = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state, state_nxt;
  logic   rdy;
  logic   pcwrite, branch;
  logic   mem_req_c, memwrite_c, irwrite_c, regwrite_c, done_c, illegal_c;

  // Without a handshake the memory is assumed to answer in one cycle.
  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state and per-phase datapath controls.
  always_comb begin
    state_nxt  = FETCH;
    mem_req_c  = 1'b0;
    memwrite_c = 1'b0;
    iord       = 1'b0;
    irwrite_c  = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    case (state)
      FETCH: begin
        mem_req_c  = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite_c  = rdy;
        pcwrite    = rdy;
        state_nxt  = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BEQ;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JUMP;
          default: begin
            state_nxt = FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_nxt  = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        state_nxt = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      MEMWR: begin
        mem_req_c  = 1'b1;
        memwrite_c = 1'b1;
        iord       = 1'b1;
        done_c     = rdy;
        state_nxt  = rdy ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca   = 1'b1;
        state_nxt = ALUWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            alucontrol = 3'b010;
            illegal_c  = 1'b1;
          end
        endcase
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      BEQ: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        done_c     = 1'b1;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        state_nxt  = ADDIWB;
      end
      ADDIWB: begin
        regwrite_c = 1'b1;
        done_c     = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        done_c  = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Side-effecting strobes are held off for as long as reset is asserted.
  assign mem_req    = mem_req_c  & reset;
  assign memwrite   = memwrite_c & reset;
  assign irwrite    = irwrite_c  & reset;
  assign pcen       = (pcwrite | (branch & zero)) & reset;
  assign regwrite   = regwrite_c & reset;
  assign instr_done = done_c     & reset;
  assign illegal_op = illegal_c  & reset;
  assign dbg_state  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle phase trace (states, wait cycles, control values), then replayed
// against the DUT with mem_ready/zero/op/funct driven from that trace.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca, regdst, memtoreg, regwrite, instr_done, illegal_op;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    int st;  bit rdy;
    bit mreq, mwr, iord, irw, pcen, regw, done, ill;
    int aluc, pcsrc, srca, srcb, rdst, m2r;
  } cyc_t;

  cyc_t q[$];

  multicycle_ctrl #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
    .iord(iord), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (op=%b funct=%b t=%0t)", tag, got, exp, op, funct, $time);
    end
  endtask

  function automatic cyc_t blank(input int st);
    cyc_t c;
    c = '{st: st, rdy: 1'($urandom), mreq: 0, mwr: 0, iord: 0, irw: 0, pcen: 0,
          regw: 0, done: 0, ill: 0, aluc: 0, pcsrc: 0, srca: 0, srcb: 0, rdst: 0, m2r: 0};
    return c;
  endfunction

  // ALU operation requested by an R-type funct; unknown functs add, flagged.
  function automatic int alu_of(input logic [5:0] f, output bit bad);
    bad = 0;
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default: begin bad = 1; return 2; end
    endcase
  endfunction

  // Expected cycle-by-cycle trace of one instruction.
  // wf/wm: number of cycles the fetch / data access is kept waiting.
  task automatic gen_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                           input int wf, input int wm);
    cyc_t c;
    bit bad;
    for (int i = 0; i <= wf; i++) begin
      c = blank(0); c.rdy = (i == wf); c.mreq = 1; c.srcb = 1; c.aluc = 2;
      c.irw = c.rdy; c.pcen = c.rdy; q.push_back(c);
    end
    c = blank(1); c.srcb = 3; c.aluc = 2;
    c.ill = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
    q.push_back(c);
    case (o)
      6'b100011, 6'b101011: begin
        c = blank(2); c.srca = 1; c.srcb = 2; c.aluc = 2; q.push_back(c);
        for (int i = 0; i <= wm; i++) begin
          c = blank(o == 6'b100011 ? 3 : 5); c.rdy = (i == wm); c.mreq = 1; c.iord = 1;
          if (o == 6'b101011) begin c.mwr = 1; c.done = c.rdy; end
          q.push_back(c);
        end
        if (o == 6'b100011) begin
          c = blank(4); c.m2r = 1; c.regw = 1; c.done = 1; q.push_back(c);
        end
      end
      6'b000000: begin
        c = blank(6); c.srca = 1; c.aluc = alu_of(f, bad); c.ill = bad; q.push_back(c);
        c = blank(7); c.rdst = 1; c.regw = 1; c.done = 1; q.push_back(c);
      end
      6'b000100: begin
        c = blank(8); c.srca = 1; c.aluc = 6; c.pcsrc = 1; c.pcen = z; c.done = 1; q.push_back(c);
      end
      6'b001000: begin
        c = blank(9); c.srca = 1; c.srcb = 2; c.aluc = 2; q.push_back(c);
        c = blank(10); c.regw = 1; c.done = 1; q.push_back(c);
      end
      6'b000010: begin
        c = blank(11); c.pcsrc = 2; c.pcen = 1; c.done = 1; q.push_back(c);
      end
      default: ;
    endcase
  endtask

  // Apply one expected cycle: drive at posedge+1, check at negedge.
  task automatic run_one(input cyc_t c);
    mem_ready = c.rdy;
    @(negedge clk);
    chk("state",      32'(dbg_state),  32'(c.st));
    chk("mem_req",    32'(mem_req),    32'(c.mreq));
    chk("memwrite",   32'(memwrite),   32'(c.mwr));
    chk("iord",       32'(iord),       32'(c.iord));
    chk("irwrite",    32'(irwrite),    32'(c.irw));
    chk("pcen",       32'(pcen),       32'(c.pcen));
    chk("regwrite",   32'(regwrite),   32'(c.regw));
    chk("instr_done", 32'(instr_done), 32'(c.done));
    chk("illegal_op", 32'(illegal_op), 32'(c.ill));
    chk("alucontrol", 32'(alucontrol), 32'(c.aluc));
    chk("pcsrc",      32'(pcsrc),      32'(c.pcsrc));
    chk("alusrca",    32'(alusrca),    32'(c.srca));
    chk("alusrcb",    32'(alusrcb),    32'(c.srcb));
    chk("regdst",     32'(regdst),     32'(c.rdst));
    chk("memtoreg",   32'(memtoreg),   32'(c.m2r));
    @(posedge clk); #1;
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                          input int wf, input int wm);
    op = o; funct = f; zero = z;
    gen_instr(o, f, z, wf, wm);
    while (q.size() > 0) run_one(q.pop_front());
  endtask

  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] o, f;
    reset = 1'b0; op = 6'b100011; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("rst_state",   32'(dbg_state), 0);
    chk("rst_mem_req", 32'(mem_req),   0);
    chk("rst_irwrite", 32'(irwrite),   0);
    chk("rst_pcen",    32'(pcen),      0);
    @(posedge clk); #1; reset = 1'b1;

    // Directed cases
    do_instr(6'b100011, 6'b000000, 0, 0, 0);   // lw, 5 cycles
    do_instr(6'b000000, 6'b100010, 0, 0, 0);   // sub
    do_instr(6'b000000, 6'b101010, 0, 0, 0);   // slt
    do_instr(6'b000000, 6'b111111, 0, 0, 0);   // bad funct still writes back
    do_instr(6'b000100, 6'b000000, 1, 0, 0);   // beq taken
    do_instr(6'b000100, 6'b000000, 0, 0, 0);   // beq not taken
    do_instr(6'b001000, 6'b000000, 0, 3, 0);   // fetch waits 3 cycles
    do_instr(6'b111111, 6'b000000, 0, 0, 0);   // illegal op
    do_instr(6'b000010, 6'b000000, 0, 0, 0);   // jump
    do_instr(6'b101011, 6'b000000, 0, 1, 2);   // sw with waits
    do_instr(6'b100011, 6'b000000, 0, 2, 3);   // lw with waits

    // Reset in the middle of a stalled store
    op = 6'b101011; funct = '0; zero = 0;
    gen_instr(6'b101011, 6'b000000, 0, 0, 5);
    for (int i = 0; i < 4; i++) run_one(q.pop_front());
    q.delete();
    #2;
    chk("memwr_before_rst", 32'(memwrite), 1);
    reset = 1'b0; #1;
    chk("abort_state",    32'(dbg_state), 0);
    chk("abort_memwrite", 32'(memwrite),  0);
    chk("abort_mem_req",  32'(mem_req),   0);
    chk("abort_regwrite", 32'(regwrite),  0);
    @(posedge clk); @(posedge clk); #1;
    chk("held_state", 32'(dbg_state), 0);
    reset = 1'b1;
    do_instr(6'b100011, 6'b000000, 1, 0, 1);

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do o = 6'($urandom);
        while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      do_instr(o, f, 1'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
